// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster engine. A clock divider produces a pixel strobe
// (pix_ce). Horizontal and vertical counters run on that strobe and are
// decoded into the active, hsync and vsync regions. A registered output stage
// drives rgb/hs/vs/de one pixel after the counters. rgb comes from one of four
// sources, and the source is latched once per frame.
//
// Ports:
//   clk16M       system clock
//   rst          asynchronous reset, active-low
//   mode         source select: 0 pix_in, 1 colour bars, 2 checkerboard,
//                3 solid colour (sampled at the first pixel of each frame)
//   solid_color  colour used in mode 3
//   pix_in       external pixel used in mode 0, sampled while pix_req is high
//   pix_req      high in the clk16M cycle in which pix_in is sampled
//   x, y         current horizontal / vertical counter values
//   rgb          pixel output, zero while blanked, channel order {R,G,B}
//   hs, vs       horizontal / vertical sync with programmable polarity
//   de           data enable, aligned with rgb
//   frame_start  one-cycle pulse coincident with the first active pixel
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 1,
  parameter int COLOR_W  = 6,
  parameter int CHK_LOG  = 3,
  parameter int CW       = 11
) (
  input  logic               clk16M,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic [COLOR_W-1:0] solid_color,
  input  logic [COLOR_W-1:0] pix_in,
  output logic               pix_req,
  output logic [CW-1:0]      x,
  output logic [CW-1:0]      y,
  output logic [COLOR_W-1:0] rgb,
  output logic               hs,
  output logic               vs,
  output logic               de,
  output logic               frame_start
);

  typedef enum logic [1:0] {
    SRC_PIX   = 2'd0,
    SRC_BARS  = 2'd1,
    SRC_CHECK = 2'd2,
    SRC_SOLID = 2'd3
  } src_e;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CH_W    = COLOR_W / 3;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CW-1:0]    H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0]    V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0]    H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0]    V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0]    HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0]    HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0]    VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0]    VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0]   div;
  logic               pix_ce;
  logic [CW-1:0]      hcnt;
  logic [CW-1:0]      vcnt;
  logic               origin;
  logic               active;
  logic               hs_raw;
  logic               vs_raw;
  src_e               mode_q;
  src_e               mode_cur;
  logic [2:0]         bar_idx;
  logic [COLOR_W-1:0] src_rgb;

  // ---------------------------------------------------------------------
  // Pixel strobe divider. With CLK_DIV=1 the divider stays at 0 and pix_ce
  // is permanently high.
  // ---------------------------------------------------------------------
  assign pix_ce = (div == DIV_LAST);

  // NOTE: every register is assigned with <= so that all of them sample
  // values from before the clock edge, whatever order the blocks run in.
  always_ff @(posedge clk16M or negedge rst) begin
    if (!rst) begin
      div <= '0;
    end else if (pix_ce) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------
  always_ff @(posedge clk16M or negedge rst) begin
    if (!rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_ce) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + CW'(1);
      end else begin
        hcnt <= hcnt + CW'(1);
      end
    end
  end

  assign x      = hcnt;
  assign y      = vcnt;
  assign origin = (hcnt == '0) && (vcnt == '0);
  assign active = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign hs_raw = (hcnt >= HS_START) && (hcnt < HS_END);
  assign vs_raw = (vcnt >= VS_START) && (vcnt < VS_END);

  // At the frame origin mode_q is being loaded in this same cycle. The
  // incoming mode is forwarded so that the first pixel of the frame already
  // uses the new source. Everywhere else the latched mode is used, so a
  // change in the middle of a frame does not show until the next frame.
  assign mode_cur = origin ? src_e'(mode) : mode_q;

  assign pix_req = pix_ce && active && (mode_cur == SRC_PIX);

  // ---------------------------------------------------------------------
  // Colour bar index: b = floor(hcnt*8 / H_ACTIVE). This is found by
  // comparing hcnt against the constant thresholds ceil(k*H_ACTIVE/8). The
  // thresholds rise with k, so the last one that is met gives the index.
  // ---------------------------------------------------------------------
  // NOTE: every variable written in an always_comb gets a default value
  // first, so that no path can leave it unassigned and infer a latch.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (hcnt >= CW'((k * H_ACTIVE + 7) / 8)) begin
        bar_idx = 3'(k);
      end
    end
  end

  always_comb begin
    src_rgb = '0;
    case (mode_cur)
      SRC_PIX:   src_rgb = pix_in;
      SRC_BARS:  src_rgb = {{CH_W{bar_idx[2]}}, {CH_W{bar_idx[1]}},
                            {CH_W{bar_idx[0]}}};
      SRC_CHECK: src_rgb = {COLOR_W{hcnt[CHK_LOG] ^ vcnt[CHK_LOG]}};
      SRC_SOLID: src_rgb = solid_color;
      default:   src_rgb = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output stage: one pixel of latency behind the counters. It is loaded
  // only on pix_ce, so the outputs hold between strobes. frame_start is
  // evaluated on every clock so that it lasts exactly one clk16M cycle.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk16M or negedge rst) begin
    if (!rst) begin
      mode_q      <= SRC_PIX;
      de          <= 1'b0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      rgb         <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_ce && origin;
      if (pix_ce) begin
        if (origin) begin
          mode_q <= mode_cur;
        end
        de  <= active;
        hs  <= hs_raw ? HS_POL : ~HS_POL;
        vs  <= vs_raw ? VS_POL : ~VS_POL;
        rgb <= active ? src_rgb : '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Directed bench for vga_timing_gen on a small raster: 8+2+3+3 pixels per
// line, 4+1+2+1 lines per frame, CLK_DIV=2, CHK_LOG=1. A cycle-level model
// predicts the outputs for every clock. The prediction is queued when the
// stimulus is driven and is popped and compared after the next rising edge.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 3;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CLK_DIV  = 2;
  localparam int COLOR_W  = 6;
  localparam int CW       = 11;

  typedef struct packed {
    logic               de;
    logic               hs;
    logic               vs;
    logic               fs;
    logic [COLOR_W-1:0] rgb;
  } exp_t;

  logic               clk16M = 1'b0;
  logic               rst = 1'b0;
  logic [1:0]         mode = 2'd0;
  logic [COLOR_W-1:0] solid_color = 6'b110011;
  logic [COLOR_W-1:0] pix_in = '0;
  logic               pix_req;
  logic [CW-1:0]      x;
  logic [CW-1:0]      y;
  logic [COLOR_W-1:0] rgb;
  logic               hs;
  logic               vs;
  logic               de;
  logic               frame_start;

  int   compared = 0;
  int   mismatched = 0;
  int   pclk = 0;
  int   fs_seen = 0;
  int   de_clks = 0;
  logic [1:0] mode_m = 2'd0;
  exp_t last_exp;
  exp_t sb_q[$];
  logic [COLOR_W-1:0] bar_tbl [8] = '{6'h00, 6'h03, 6'h0C, 6'h0F,
                                      6'h30, 6'h33, 6'h3C, 6'h3F};

  always #5 clk16M = ~clk16M;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(CLK_DIV), .COLOR_W(COLOR_W),
    .CHK_LOG(1), .CW(CW)
  ) dut (
    .clk16M      (clk16M),
    .rst         (rst),
    .mode        (mode),
    .solid_color (solid_color),
    .pix_in      (pix_in),
    .pix_req     (pix_req),
    .x           (x),
    .y           (y),
    .rgb         (rgb),
    .hs          (hs),
    .vs          (vs),
    .de          (de),
    .frame_start (frame_start)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e.de  = 1'b0;
    e.hs  = 1'b1;
    e.vs  = 1'b1;
    e.fs  = 1'b0;
    e.rgb = '0;
    return e;
  endfunction

  task automatic check_reset_values(input string phase);
    check({phase, "_hs"},  hs, 1);
    check({phase, "_vs"},  vs, 1);
    check({phase, "_rgb"}, rgb, 0);
    check({phase, "_de"},  de, 0);
    check({phase, "_fs"},  frame_start, 0);
    check({phase, "_x"},   x, 0);
    check({phase, "_y"},   y, 0);
  endtask

  // This task is entered on a falling edge. It drives pix_in, checks the
  // combinational outputs, and queues the predicted registered outputs.
  // It then waits for the rising edge and compares against the queue.
  task automatic step();
    int         k;
    int         h;
    int         v;
    bit         ce;
    bit         org;
    bit         act;
    logic [1:0] m;
    exp_t       e;
    exp_t       got;
    k   = pclk / CLK_DIV;
    h   = k % H_TOTAL;
    v   = (k / H_TOTAL) % V_TOTAL;
    ce  = (pclk % CLK_DIV) == (CLK_DIV - 1);
    org = (h == 0) && (v == 0);
    act = (h < H_ACTIVE) && (v < V_ACTIVE);
    m   = org ? mode : mode_m;
    pix_in = COLOR_W'($urandom_range(0, 63));
    check("x", x, h);
    check("y", y, v);
    check("pix_req", pix_req, ce && act && (m == 2'd0));
    e    = last_exp;
    e.fs = 1'b0;
    if (ce) begin
      if (org) mode_m = mode;
      e.de  = act;
      e.hs  = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
      e.vs  = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
      e.fs  = org;
      e.rgb = '0;
      if (act) begin
        case (m)
          2'd0:    e.rgb = pix_in;
          2'd1:    e.rgb = bar_tbl[h];
          2'd2:    e.rgb = (((h >> 1) ^ (v >> 1)) & 1) != 0 ? 6'h3F : 6'h00;
          default: e.rgb = solid_color;
        endcase
      end
    end
    sb_q.push_back(e);
    last_exp = e;
    @(posedge clk16M);
    #1;
    pclk++;
    check("sb_depth", sb_q.size(), 1);
    e   = sb_q.pop_front();
    got = '{de: de, hs: hs, vs: vs, fs: frame_start, rgb: rgb};
    check("de",  got.de,  e.de);
    check("hs",  got.hs,  e.hs);
    check("vs",  got.vs,  e.vs);
    check("frame_start", got.fs, e.fs);
    check("rgb", got.rgb, e.rgb);
    if (frame_start) fs_seen++;
    if (de) de_clks++;
    @(negedge clk16M);
  endtask

  initial begin
    // Outputs while the design is held in reset.
    rst = 1'b0;
    repeat (3) @(negedge clk16M);
    check_reset_values("in_reset");

    // Release the reset and run two frames in mode 0.
    rst      = 1'b1;
    pclk     = 0;
    mode_m   = 2'd0;
    last_exp = reset_exp();
    fs_seen  = 0;
    de_clks  = 0;
    repeat (2 * 256) step();
    check("frame_starts_2frames", fs_seen, 2);
    check("de_clks_2frames", de_clks, 2 * 64);

    // Solid colour frame.
    mode = 2'd3;
    repeat (256) step();

    // Colour bar frame.
    mode = 2'd1;
    repeat (256) step();

    // A mode-0 frame that switches to checkerboard partway through. The
    // switch must not show until the next frame.
    mode = 2'd0;
    repeat (80) step();
    mode = 2'd2;
    repeat (176) step();
    repeat (256) step();

    // Run up to hcnt=5, vcnt=2, then assert the reset partway through the line.
    for (int i = 0; i < 300; i++) begin
      if (((pclk / 2) % H_TOTAL) == 5 && (((pclk / 2) / H_TOTAL) % V_TOTAL) == 2)
        break;
      step();
    end
    check("mid_line_hcnt", x, 5);
    check("mid_line_vcnt", y, 2);
    rst = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(negedge clk16M);
    @(negedge clk16M);
    rst      = 1'b1;
    pclk     = 0;
    last_exp = reset_exp();
    sb_q.delete();
    fs_seen  = 0;
    // frame_start is due after the second rising edge following release.
    step();
    check("fs_after_1st_edge", fs_seen, 0);
    step();
    check("fs_after_2nd_edge", fs_seen, 1);
    repeat (254) step();
    check("frame_starts_after_reset", fs_seen, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
